lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Timed HD44780-class sequencer that owns the character-LCD pins on the DE2 board. It performs the power-on initialisation, then accepts 32-character frames (256 bits) from the display formatter through a valid/ready handshake. Each accepted frame is written as two addressed 16-character lines with per-command execution waits. It replaces free-running refresh: the LCD bus moves only when a frame is offered.

## Interface
- POWERUP_CYC, 750000, idle cycles after reset before the first command (15 ms at 50 MHz)
- EN_HIGH_CYC, 25, cycles lcd_en is held high per write (500 ns)
- CMD_CYC, 2500, post-strobe wait for normal commands and data (50 us)
- LONG_CYC, 82000, post-strobe wait for clear display (1.64 ms)
- CLOCK_50  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- frame_in  in  256  char k of line 1 is [8k+7:8k]; char k of line 2 is [128+8k+7:128+8k]; k = 0..15
- frame_valid  in  1  frame_in is offered
- frame_ready  out  1  controller is idle and will accept a frame
- frame_done  out  1  one-cycle pulse after the last wait of a frame completes
- bl_in  in  1  backlight request
- lcd_on  out  1  panel power
- lcd_blon  out  1  backlight, registered copy of bl_in
- lcd_en  out  1  write strobe
- lcd_rs  out  1  0 command, 1 data
- lcd_rw  out  1  tied 0, write only
- lcd_data  out  8  bus byte

## Operation
- One clock; reset is asynchronous and active-high.
- Reset values: lcd_on 0, lcd_blon 0, lcd_en 0, lcd_rs 0, lcd_rw 0, lcd_data 0x00, frame_ready 0, frame_done 0.
- State sequence: PWR_WAIT → INIT → IDLE → ADDR1 → LINE1 → ADDR2 → LINE2 → DONE → IDLE.
- PWR_WAIT
  - lcd_on goes 1 in the first cycle after rst falls.
  - The state counts POWERUP_CYC cycles.
- INIT writes, in order: 0x38, 0x38, 0x38, 0x0C, 0x01 (macro-dependent), 0x06.
- IDLE
  - frame_ready is 1.
  - frame_valid and frame_ready high on the same edge latches frame_in into an internal 256-bit register.
  - frame_ready drops on the next cycle.
- ADDR1 writes command 0x80.
- LINE1 writes 16 data bytes, k = 0..15, with rs = 1.
- ADDR2 writes command 0xC0.
- LINE2 writes 16 data bytes.
- DONE pulses frame_done for one cycle, then returns to IDLE.
- Every write is one transaction:
  - 1 setup cycle: lcd_en 0, rs and data driven.
  - EN_HIGH_CYC cycles: lcd_en 1.
  - Wait cycles: lcd_en 0, CMD_CYC (LONG_CYC for 0x01).
  - lcd_rs and lcd_data are stable for the whole transaction.
- Continuous refresh is achieved by upstream holding frame_valid high: a new frame is accepted on the cycle IDLE is re-entered.
- frame_in changes while not accepted are ignored. The latched copy is used for the entire frame, so there is no tearing.
- A single shared down-counter of at least 20 bits serves all delays. A character index counter of 4 bits wraps 15→0 at each line end.

## Timing
- First lcd_en rise: POWERUP_CYC + 1 cycles after the first edge with rst low.
- Transaction length: 1 + EN_HIGH_CYC + wait cycles.
- Frame latency: acceptance edge to frame_done equals 34 transactions plus 1 cycle.
- frame_ready is never 1 during PWR_WAIT, INIT, or while a frame is in flight.
- frame_valid asserted during INIT: the frame is held off, not dropped, and is accepted on the first IDLE cycle.
- bl_in to lcd_blon latency is 1 cycle, independent of the state machine.
- rst mid-frame or mid-init:
  - lcd_en falls immediately (asynchronous).
  - The latched frame is discarded and no frame_done is produced.
  - After release, the full PWR_WAIT and INIT sequence repeats.

## Configuration
- LCD_INIT_CLEAR_EN defined: INIT includes 0x01 with a LONG_CYC wait (6 init commands).
- LCD_INIT_CLEAR_EN undefined: 0x01 is omitted (5 init commands). DDRAM contents are then undefined until the first frame.

## Test plan
Bench parameters for all scenarios: POWERUP_CYC = 100, EN_HIGH_CYC = 3, CMD_CYC = 10, LONG_CYC = 50. Cycle counts are measured from the rst release edge.
- Init, with LCD_INIT_CLEAR_EN: release rst → 6 strobes carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, all with rs = 0, then frame_ready = 1 at cycle 100 + 5·14 + 54 = 224 ±1.
- Init, without LCD_INIT_CLEAR_EN: release rst → 5 strobes carrying 0x38, 0x38, 0x38, 0x0C, 0x06 and no 0x01.
- Single frame: frame_in = ASCII "2024-05-17 12:34" / "Friday     Alarm", pulse frame_valid → strobe order is 0x80, the 16 line-1 bytes in order, 0xC0, the 16 line-2 bytes; frame_done arrives 34·14 + 1 = 477 cycles after acceptance.
- Frame latched mid-frame: change frame_in in cycle 50 of a frame → all written bytes match the frame_in value captured at acceptance.
- Held valid: keep frame_valid high → back-to-back frames, each frame_done followed by acceptance in the first IDLE cycle; lcd_en is never high while frame_ready = 1.
- Reset mid-frame: assert rst during the strobe of line-2 char 5 → lcd_en is 0 within the same cycle and no frame_done; after release, the full init repeats before frame_ready = 1.

Source files
------------

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - timed HD44780 init and 32-character frame write sequencer
//
// Build option: define LCD_INIT_CLEAR_EN to include the clear-display command
// (0x01, long wait) in the power-on init sequence.
//
// Ports:
//   CLOCK_50     system clock
//   rst          asynchronous active-high reset
//   frame_in     256-bit frame; line 1 char k at [8k+7:8k], line 2 char k at [128+8k+7:128+8k]
//   frame_valid  frame_in is offered
//   frame_ready  controller idle, frame accepted when frame_valid is also high
//   frame_done   one-cycle pulse once the last write of a frame has finished
//   bl_in        backlight request
//   lcd_on       panel power
//   lcd_blon     backlight (registered bl_in)
//   lcd_en       write strobe
//   lcd_rs       0 command, 1 data
//   lcd_rw       always 0
//   lcd_data     bus byte
module lcd_ctrl #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned EN_HIGH_CYC = 25,
    parameter int unsigned CMD_CYC     = 2500,
    parameter int unsigned LONG_CYC    = 82000
) (
    input  logic         CLOCK_50,
    input  logic         rst,
    input  logic [255:0] frame_in,
    input  logic         frame_valid,
    output logic         frame_ready,
    output logic         frame_done,
    input  logic         bl_in,
    output logic         lcd_on,
    output logic         lcd_blon,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data
);

    // One shared delay counter, wide enough for the longest delay and never
    // narrower than 20 bits.
    localparam int unsigned MAX_A = (POWERUP_CYC > LONG_CYC) ? POWERUP_CYC : LONG_CYC;
    localparam int unsigned MAX_B = (MAX_A > CMD_CYC) ? MAX_A : CMD_CYC;
    localparam int unsigned MAX_C = (MAX_B > EN_HIGH_CYC) ? MAX_B : EN_HIGH_CYC;
    localparam int          CNT_W = ($clog2(MAX_C + 1) > 20) ? $clog2(MAX_C + 1) : 20;

`ifdef LCD_INIT_CLEAR_EN
    localparam logic [2:0] INIT_LAST = 3'd5;
`else
    localparam logic [2:0] INIT_LAST = 3'd4;
`endif

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT,
        S_IDLE,
        S_ADDR1,
        S_LINE1,
        S_ADDR2,
        S_LINE2,
        S_DONE
    } state_t;

    // Every bus write is SETUP (1 cycle) -> EN (strobe high) -> WAIT (execution time).
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         init_idx_q, init_idx_d;
    logic [3:0]         char_idx_q, char_idx_d;
    logic [255:0]       frame_q, frame_d;
    logic               frame_done_q, frame_done_d;
    logic               lcd_en_q, lcd_en_d;
    logic               lcd_rs_q;
    logic [7:0]         lcd_data_q;
    logic               lcd_on_q;
    logic               lcd_blon_q;

    logic               txn_last;
    logic [CNT_W-1:0]   wait_m1;
    logic               load_byte;
    logic               next_rs;
    logic [7:0]         next_byte;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
`ifdef LCD_INIT_CLEAR_EN
            3'd4:             return 8'h01;
`endif
            default:          return 8'h06;
        endcase
    endfunction

    function automatic logic is_write(input state_t s);
        return (s == S_INIT) || (s == S_ADDR1) || (s == S_LINE1) ||
               (s == S_ADDR2) || (s == S_LINE2);
    endfunction

    // Only a clear-display command needs the long execution wait; the byte
    // being written is already held in the output register.
    assign wait_m1 = (!lcd_rs_q && lcd_data_q == 8'h01) ? CNT_W'(LONG_CYC - 1)
                                                         : CNT_W'(CMD_CYC - 1);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        init_idx_d   = init_idx_q;
        char_idx_d   = char_idx_q;
        frame_d      = frame_q;
        frame_done_d = 1'b0;
        txn_last     = 1'b0;

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_INIT;
                    phase_d    = PH_SETUP;
                    init_idx_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_IDLE: begin
                if (frame_valid) begin
                    state_d    = S_ADDR1;
                    phase_d    = PH_SETUP;
                    char_idx_d = '0;
                    frame_d    = frame_in;
                end
            end

            S_DONE: begin
                state_d      = S_IDLE;
                frame_done_d = 1'b1;
            end

            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_EN;
                        cnt_d   = CNT_W'(EN_HIGH_CYC - 1);
                    end
                    PH_EN: begin
                        if (cnt_q == '0) begin
                            phase_d = PH_WAIT;
                            cnt_d   = wait_m1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == '0) begin
                            txn_last = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                endcase

                if (txn_last) begin
                    phase_d = PH_SETUP;
                    case (state_q)
                        S_INIT: begin
                            if (init_idx_q == INIT_LAST) begin
                                state_d = S_IDLE;
                            end else begin
                                init_idx_d = init_idx_q + 3'd1;
                            end
                        end
                        S_ADDR1: state_d = S_LINE1;
                        S_LINE1: begin
                            // 4-bit index wraps 15 -> 0, ready for line 2
                            char_idx_d = char_idx_q + 4'd1;
                            if (char_idx_q == 4'd15) begin
                                state_d = S_ADDR2;
                            end
                        end
                        S_ADDR2: state_d = S_LINE2;
                        S_LINE2: begin
                            char_idx_d = char_idx_q + 4'd1;
                            if (char_idx_q == 4'd15) begin
                                state_d = S_DONE;
                            end
                        end
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
    end

    // Byte for the transaction that starts next cycle. It is loaded once at
    // the setup cycle so rs/data stay frozen for the whole transaction.
    always_comb begin
        next_rs   = 1'b0;
        next_byte = 8'h00;
        case (state_d)
            S_INIT:  next_byte = init_cmd(init_idx_d);
            S_ADDR1: next_byte = 8'h80;
            S_LINE1: begin
                next_rs   = 1'b1;
                next_byte = frame_d[{1'b0, char_idx_d, 3'b000} +: 8];
            end
            S_ADDR2: next_byte = 8'hC0;
            S_LINE2: begin
                next_rs   = 1'b1;
                next_byte = frame_d[{1'b1, char_idx_d, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign load_byte = is_write(state_d) && (phase_d == PH_SETUP);
    assign lcd_en_d  = is_write(state_d) && (phase_d == PH_EN);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q      <= S_PWR_WAIT;
            phase_q      <= PH_SETUP;
            cnt_q        <= CNT_W'(POWERUP_CYC);
            init_idx_q   <= '0;
            char_idx_q   <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
            lcd_en_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            lcd_on_q     <= 1'b0;
            lcd_blon_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            init_idx_q   <= init_idx_d;
            char_idx_q   <= char_idx_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
            lcd_en_q     <= lcd_en_d;
            lcd_on_q     <= 1'b1;
            lcd_blon_q   <= bl_in;
            if (load_byte) begin
                lcd_rs_q   <= next_rs;
                lcd_data_q <= next_byte;
            end
        end
    end

    assign frame_ready = (state_q == S_IDLE);
    assign frame_done  = frame_done_q;
    assign lcd_on      = lcd_on_q;
    assign lcd_blon    = lcd_blon_q;
    assign lcd_en      = lcd_en_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = 1'b0;
    assign lcd_data    = lcd_data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - self-checking bench for lcd_ctrl
module tb_lcd_ctrl;

    localparam int P         = 100;
    localparam int EH        = 3;
    localparam int CC        = 10;
    localparam int LC        = 50;
    localparam int TXN       = 1 + EH + CC;
    localparam int FRAME_LAT = 34 * TXN + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] frame_in;
    logic         frame_valid;
    logic         frame_ready;
    logic         frame_done;
    logic         bl_in;
    logic         lcd_on;
    logic         lcd_blon;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .POWERUP_CYC (P),
        .EN_HIGH_CYC (EH),
        .CMD_CYC     (CC),
        .LONG_CYC    (LC)
    ) dut (
        .CLOCK_50    (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .bl_in       (bl_in),
        .lcd_on      (lcd_on),
        .lcd_blon    (lcd_blon),
        .lcd_en      (lcd_en),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_data    (lcd_data)
    );

    typedef struct {
        string l1;
        string l2;
        bit    bl;
        int    chg_at;
        int    exp_lat;
        bit    exp_blon;
    } vec_t;

    vec_t        vecs[4];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = -1;
    logic [8:0]  got[$];
    int          rise_cyc[$];
    logic [8:0]  exp_q[$];
    int          exp_ready = 0;
    logic        en_prev = 1'b0;
    logic [8:0]  hold_v = '0;
    int          unstable = 0;
    int          overlap = 0;
    int          done_cnt = 0;
    int          last_done = -1;
    int          blon_bad = 0;
    int          ready_run = 0;
    int          ready_run_max = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) cyc = -1;
        else cyc++;
        if (lcd_en && !en_prev) begin
            got.push_back({lcd_rs, lcd_data});
            rise_cyc.push_back(cyc);
            hold_v = {lcd_rs, lcd_data};
        end else if (lcd_en && ({lcd_rs, lcd_data} !== hold_v)) begin
            unstable++;
        end
        if (lcd_en && frame_ready) overlap++;
        if (frame_done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (frame_ready) begin
            ready_run++;
            if (ready_run > ready_run_max) ready_run_max = ready_run;
        end else begin
            ready_run = 0;
        end
        if (!rst && lcd_blon !== bl_in) blon_bad++;
        en_prev = lcd_en;
    endtask

    function automatic logic [255:0] mk(input string a, input string b);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8]       = a.getc(k);
            r[128 + 8*k +: 8] = b.getc(k);
        end
        return r;
    endfunction

    task automatic model_init();
        logic [7:0] cmds[$];
        cmds = '{8'h38, 8'h38, 8'h38, 8'h0C};
`ifdef LCD_INIT_CLEAR_EN
        cmds.push_back(8'h01);
`endif
        cmds.push_back(8'h06);
        exp_q.delete();
        exp_ready = P;
        foreach (cmds[i]) begin
            exp_q.push_back({1'b0, cmds[i]});
            exp_ready += 1 + EH + ((cmds[i] == 8'h01) ? LC : CC);
        end
    endtask

    task automatic model_frame(input logic [255:0] f, input int copies);
        exp_q.delete();
        for (int c = 0; c < copies; c++) begin
            exp_q.push_back({1'b0, 8'h80});
            for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, f[8*k +: 8]});
            exp_q.push_back({1'b0, 8'hC0});
            for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, f[128 + 8*k +: 8]});
        end
    endtask

    task automatic compare_strobes(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("%s_strobe%0d", tag, i), got[i], exp_q[i]);
    endtask

    task automatic reset_and_init(output int ready_at);
        int   t;
        logic on0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_lcd_on", lcd_on, 0);
        check("rst_lcd_blon", lcd_blon, 0);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_frame_done", frame_done, 0);
        got.delete();
        rise_cyc.delete();
        rst = 1'b0;
        on0 = 1'b0;
        ready_at = -1;
        t = 0;
        while (ready_at < 0 && t < 2000) begin
            tick();
            t++;
            if (cyc == 0) on0 = lcd_on;
            if (frame_ready) ready_at = cyc;
        end
        model_init();
        check("init_lcd_on_cycle0", on0, 1);
        check("init_ready_cycle", ready_at, exp_ready);
        check("init_first_en_rise", (rise_cyc.size() > 0) ? rise_cyc[0] : -1, P + 1);
        compare_strobes("init");
    endtask

    task automatic run_frame(input logic [255:0] f, input int chg_at, input bit rnd,
                             input int exp_acc, input int exp_lat, input string tag);
        int t;
        int acc;
        int d0;
        got.delete();
        frame_in    = f;
        frame_valid = 1'b1;
        t = 0;
        while (!frame_ready && t < 2000) begin
            tick();
            t++;
        end
        check({tag, "_ready_seen"}, frame_ready, 1);
        tick();
        acc = cyc;
        frame_valid = 1'b0;
        if (exp_acc >= 0) check({tag, "_accept_cycle"}, acc, exp_acc);
        d0 = done_cnt;
        t = 0;
        while (done_cnt == d0 && t < FRAME_LAT + 50) begin
            tick();
            t++;
            if (cyc - acc == chg_at) frame_in = ~f;
            if (rnd) begin
                for (int k = 0; k < 8; k++) frame_in[32*k +: 32] = $urandom();
                bl_in = 1'($urandom_range(0, 1));
            end
        end
        check({tag, "_done_latency"}, (done_cnt == d0) ? -1 : (last_done - acc), exp_lat);
        model_frame(f, 1);
        compare_strobes(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d expected finish", cyc);
        $fatal(1);
    end

    initial begin
        int           r;
        int           t;
        int           d0;
        logic [255:0] f;
        logic [255:0] g;

        vecs[0] = '{"2024-05-17 12:34", "Friday     Alarm", 1'b1, -1,  FRAME_LAT, 1'b1};
        vecs[1] = '{"ABCDEFGHIJKLMNOP", "abcdefghijklmnop", 1'b0, 50,  FRAME_LAT, 1'b0};
        vecs[2] = '{"0123456789ABCDEF", "                ", 1'b1, 200, FRAME_LAT, 1'b1};
        vecs[3] = '{"~}|{zyxwvutsrqpo", "!#$%&()*+,-./012", 1'b0, 400, FRAME_LAT, 1'b0};

        rst         = 1'b1;
        frame_valid = 1'b0;
        frame_in    = '0;
        bl_in       = 1'b0;

        reset_and_init(r);

        foreach (vecs[i]) begin
            bl_in = vecs[i].bl;
            tick();
            check($sformatf("vec%0d_blon", i), lcd_blon, vecs[i].exp_blon);
            run_frame(mk(vecs[i].l1, vecs[i].l2), vecs[i].chg_at, 1'b0, -1,
                      vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 6; n++) begin
            frame_valid = 1'b0;
            repeat ($urandom_range(0, 15)) begin
                tick();
                bl_in = 1'($urandom_range(0, 1));
            end
            for (int k = 0; k < 8; k++) f[32*k +: 32] = $urandom();
            run_frame(f, -1, 1'b1, -1, FRAME_LAT, $sformatf("rand%0d", n));
        end

        f = mk("HELD VALID FRAME", "refresh loop  ok");
        frame_in    = f;
        frame_valid = 1'b1;
        t = 0;
        while (!frame_ready && t < 2000) begin
            tick();
            t++;
        end
        got.delete();
        tick();
        ready_run_max = 0;
        d0 = done_cnt;
        t = 0;
        while (done_cnt < d0 + 3 && t < 4 * FRAME_LAT) begin
            tick();
            t++;
        end
        frame_valid = 1'b0;
        check("held_done_count", done_cnt - d0, 3);
        check("held_ready_max_run", ready_run_max, 1);
        model_frame(f, 3);
        compare_strobes("held");

        f = mk("RESET TEST LINE1", "line two char 5!");
        frame_in    = f;
        frame_valid = 1'b1;
        t = 0;
        while (!frame_ready && t < 2000) begin
            tick();
            t++;
        end
        got.delete();
        tick();
        frame_valid = 1'b0;
        t = 0;
        while (got.size() < 24 && t < FRAME_LAT) begin
            tick();
            t++;
        end
        check("mid_strobe_index", got.size(), 24);
        check("mid_strobe_byte", (got.size() > 23) ? got[23] : 9'h0, {1'b1, f[128 + 40 +: 8]});
        check("mid_en_high_before_rst", lcd_en, 1);
        d0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_en_async", lcd_en, 0);
        check("mid_rst_data_async", lcd_data, 0);
        repeat (4) tick();
        check("mid_no_frame_done", done_cnt - d0, 0);

        g = mk("AFTER RESET 0001", "init held-off ok");
        frame_in    = g;
        frame_valid = 1'b1;
        reset_and_init(r);
        check("post_rst_no_frame_done", done_cnt - d0, 0);
        run_frame(g, -1, 1'b0, exp_ready + 1, FRAME_LAT, "post_rst");

        check("en_while_ready_count", overlap, 0);
        check("rs_data_unstable_count", unstable, 0);
        check("blon_latency_errors", blon_bad, 0);
        check("lcd_rw_low", lcd_rw, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
